// File: rtl/mrd_completer_pkg.sv
// rtl/mrd_completer_pkg.sv - shared TLP constants, FSM encoding and header record for mrd_completer
package mrd_completer_pkg;

  localparam logic [1:0] FMT_3DW_NODATA = 2'b00;
  localparam logic [1:0] FMT_4DW_NODATA = 2'b01;
  localparam logic [1:0] FMT_3DW_DATA   = 2'b10;
  localparam logic [4:0] TYPE_MEM       = 5'b00000;
  localparam logic [4:0] TYPE_CPL       = 5'b01010;

  localparam logic [2:0]  CPL_STS_SC   = 3'b000;
  localparam logic [2:0]  CPL_STS_UR   = 3'b001;
  localparam logic [11:0] CPL_BYTE_CNT = 12'd4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR2  = 3'd1,
    S_RDREG = 3'd2,
    S_REQ   = 3'd3,
    S_QW0   = 3'd4,
    S_QW1   = 3'd5
  } state_e;

  typedef struct packed {
    logic [15:0] req_id;
    logic [7:0]  tag;
    logic [3:0]  first_be;
    logic [2:0]  tc;
    logic [1:0]  attr;
    logic [9:0]  len;
    logic        is_64;
  } mrd_hdr_t;

  // Register file is little-endian; completion payload is carried big-endian on the link.
  function automatic logic [31:0] bswap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/mrd_completer_if.sv
// rtl/mrd_completer_if.sv - Rx/Tx local-link, Tx arbitration and register read port bundle
interface mrd_completer_if;
  logic [63:0] trn_rd;
  logic [7:0]  trn_rrem_n;
  logic        trn_rsof_n;
  logic        trn_reof_n;
  logic        trn_rsrc_rdy_n;
  logic        trn_rsrc_dsc_n;
  logic [6:0]  trn_rbar_hit_n;
  logic        trn_rnp_ok_n;
  logic [63:0] trn_td;
  logic [7:0]  trn_trem_n;
  logic        trn_tsof_n;
  logic        trn_teof_n;
  logic        trn_tsrc_rdy_n;
  logic        trn_tdst_rdy_n;
  logic        tx_req;
  logic        tx_gnt;
  logic        tx_done;
  logic [9:0]  reg_rd_addr;
  logic [31:0] reg_rd_data;

  modport master (
    input  trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rsrc_dsc_n,
           trn_rbar_hit_n, trn_tdst_rdy_n, tx_gnt, reg_rd_data,
    output trn_rnp_ok_n, trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
           tx_req, tx_done, reg_rd_addr
  );

  modport slave (
    output trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rsrc_dsc_n,
           trn_rbar_hit_n, trn_tdst_rdy_n, tx_gnt, reg_rd_data,
    input  trn_rnp_ok_n, trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
           tx_req, tx_done, reg_rd_addr
  );
endinterface

// File: rtl/mrd_hdr_parse.sv
// rtl/mrd_hdr_parse.sv - MRd decode, header field capture and supported/unsupported classification
module mrd_hdr_parse
  import mrd_completer_pkg::*;
(
  input  logic        trn_clk,
  input  logic        trn_reset,
  input  logic [63:0] rd,
  input  logic        ld_hdr,
  input  logic        ld_addr,
  output logic        sof_is_mrd,
  output logic [9:0]  beat_dw_addr,
  output mrd_hdr_t    hdr,
  output logic [6:0]  lower_addr,
  output logic        supported
);

  mrd_hdr_t   hdr_d, hdr_q;
  logic [4:0] lower_d, lower_q;
  logic       unused_bits;

  assign sof_is_mrd = (rd[60:56] == TYPE_MEM) &&
                      ((rd[62:61] == FMT_3DW_NODATA) || (rd[62:61] == FMT_4DW_NODATA));

  // MRd32 carries the address in DW2 (upper half of QW1), MRd64 low address in DW3.
  assign beat_dw_addr = hdr_q.is_64 ? rd[11:2] : rd[43:34];

  always_comb begin
    hdr_d   = hdr_q;
    lower_d = lower_q;
    if (ld_hdr) begin
      hdr_d.req_id   = rd[31:16];
      hdr_d.tag      = rd[15:8];
      hdr_d.first_be = rd[3:0];
      hdr_d.tc       = rd[54:52];
      hdr_d.attr     = rd[45:44];
      hdr_d.len      = rd[41:32];
      hdr_d.is_64    = rd[61];
    end
    if (ld_addr) begin
      lower_d = beat_dw_addr[4:0];
    end
  end

  always_ff @(posedge trn_clk or posedge trn_reset) begin
    if (trn_reset) begin
      hdr_q   <= '0;
      lower_q <= '0;
    end else begin
      hdr_q   <= hdr_d;
      lower_q <= lower_d;
    end
  end

  assign hdr         = hdr_q;
  assign lower_addr  = {lower_q, 2'b00};
  assign supported   = (hdr_q.len == 10'd1) && (hdr_q.first_be == 4'hF);
  assign unused_bits = ^{rd[63], rd[55], rd[51:46]};

endmodule

// File: rtl/mrd_completer.sv
// rtl/mrd_completer.sv - single-DW memory-read completer serving one BAR from the register file
// Optional MRD_UR_CPL_EN: answer unsupported MRd with a UR completion instead of dropping it.
module mrd_completer
  import mrd_completer_pkg::*;
#(
  parameter int BAR_HIT_IDX = 0
) (
  input  logic                  trn_clk,
  input  logic                  trn_reset,
  mrd_completer_if.master       trn,
  input  logic [15:0]           cfg_completer_id,
  output logic [15:0]           drop_cnt
);

`ifdef MRD_UR_CPL_EN
  localparam bit UR_EN = 1'b1;
`else
  localparam bit UR_EN = 1'b0;
`endif

  state_e      state_d, state_q;
  logic [63:0] td_d, td_q;
  logic [7:0]  trem_n_d, trem_n_q;
  logic        tsof_n_d, tsof_n_q, teof_n_d, teof_n_q, tsrc_rdy_n_d, tsrc_rdy_n_q;
  logic        tx_req_d, tx_req_q, tx_done_d, tx_done_q, rnp_ok_n_d, rnp_ok_n_q;
  logic [9:0]  reg_rd_addr_d, reg_rd_addr_q;
  logic [15:0] drop_cnt_d, drop_cnt_q;
  logic [31:0] data_d, data_q;

  logic        rx_beat, new_mrd, drop_inc, sof_is_mrd, supported, unused_in;
  logic [9:0]  beat_dw_addr;
  logic [6:0]  lower_addr;
  mrd_hdr_t    hdr;
  logic [31:0] cpld_dw0, ur_dw0, dw1_sc, dw1_ur, dw2;

  assign rx_beat = !trn.trn_rsrc_rdy_n;
  assign new_mrd = rx_beat && !trn.trn_rsof_n && !trn.trn_rbar_hit_n[BAR_HIT_IDX] && sof_is_mrd;

  mrd_hdr_parse u_hdr_parse (
    .trn_clk      (trn_clk),
    .trn_reset    (trn_reset),
    .rd           (trn.trn_rd),
    .ld_hdr       (state_q == S_IDLE && new_mrd),
    .ld_addr      (state_q == S_HDR2 && rx_beat),
    .sof_is_mrd   (sof_is_mrd),
    .beat_dw_addr (beat_dw_addr),
    .hdr          (hdr),
    .lower_addr   (lower_addr),
    .supported    (supported)
  );

  assign cpld_dw0 = {1'b0, FMT_3DW_DATA, TYPE_CPL, 1'b0, hdr.tc, 4'b0, 2'b00, hdr.attr, 2'b00, 10'd1};
  assign ur_dw0   = {1'b0, FMT_3DW_NODATA, TYPE_CPL, 1'b0, hdr.tc, 4'b0, 2'b00, hdr.attr, 2'b00, 10'd0};
  assign dw1_sc   = {cfg_completer_id, CPL_STS_SC, 1'b0, CPL_BYTE_CNT};
  assign dw1_ur   = {cfg_completer_id, CPL_STS_UR, 1'b0, CPL_BYTE_CNT};
  assign dw2      = {hdr.req_id, hdr.tag, 1'b0, lower_addr};

  always_comb begin
    state_d       = state_q;
    td_d          = td_q;
    trem_n_d      = trem_n_q;
    tsof_n_d      = tsof_n_q;
    teof_n_d      = teof_n_q;
    tsrc_rdy_n_d  = tsrc_rdy_n_q;
    tx_req_d      = tx_req_q;
    tx_done_d     = 1'b0;
    reg_rd_addr_d = reg_rd_addr_q;
    data_d        = data_q;
    drop_inc      = (state_q != S_IDLE) && new_mrd;
    case (state_q)
      S_IDLE: if (new_mrd) state_d = S_HDR2;
      S_HDR2: begin
        if (!trn.trn_rsrc_dsc_n) begin
          state_d = S_IDLE;
        end else if (rx_beat) begin
          reg_rd_addr_d = beat_dw_addr;
          if (supported || UR_EN) begin
            state_d = S_RDREG;
          end else begin
            state_d  = S_IDLE;
            drop_inc = 1'b1;
          end
        end
      end
      S_RDREG: begin
        state_d  = S_REQ;
        tx_req_d = 1'b1;
      end
      S_REQ: begin
        // Read data is stable by now and the address does not move until the next request.
        data_d = trn.reg_rd_data;
        if (trn.tx_gnt) begin
          state_d      = S_QW0;
          tx_req_d     = 1'b0;
          td_d         = supported ? {cpld_dw0, dw1_sc} : {ur_dw0, dw1_ur};
          trem_n_d     = 8'h00;
          tsof_n_d     = 1'b0;
          teof_n_d     = 1'b1;
          tsrc_rdy_n_d = 1'b0;
        end
      end
      S_QW0: if (!trn.trn_tdst_rdy_n) begin
        state_d  = S_QW1;
        tsof_n_d = 1'b1;
        teof_n_d = 1'b0;
        td_d     = supported ? {dw2, bswap32(data_q)} : {dw2, 32'h0};
        trem_n_d = supported ? 8'h00 : 8'h0F;
      end
      S_QW1: if (!trn.trn_tdst_rdy_n) begin
        state_d      = S_IDLE;
        td_d         = '0;
        trem_n_d     = 8'hFF;
        teof_n_d     = 1'b1;
        tsrc_rdy_n_d = 1'b1;
        tx_done_d    = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    rnp_ok_n_d = (state_d != S_IDLE);
    drop_cnt_d = (drop_inc && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end

  always_ff @(posedge trn_clk or posedge trn_reset) begin
    if (trn_reset) begin
      state_q       <= S_IDLE;
      td_q          <= '0;
      trem_n_q      <= 8'hFF;
      tsof_n_q      <= 1'b1;
      teof_n_q      <= 1'b1;
      tsrc_rdy_n_q  <= 1'b1;
      tx_req_q      <= 1'b0;
      tx_done_q     <= 1'b0;
      rnp_ok_n_q    <= 1'b0;
      reg_rd_addr_q <= '0;
      drop_cnt_q    <= '0;
      data_q        <= '0;
    end else begin
      state_q       <= state_d;
      td_q          <= td_d;
      trem_n_q      <= trem_n_d;
      tsof_n_q      <= tsof_n_d;
      teof_n_q      <= teof_n_d;
      tsrc_rdy_n_q  <= tsrc_rdy_n_d;
      tx_req_q      <= tx_req_d;
      tx_done_q     <= tx_done_d;
      rnp_ok_n_q    <= rnp_ok_n_d;
      reg_rd_addr_q <= reg_rd_addr_d;
      drop_cnt_q    <= drop_cnt_d;
      data_q        <= data_d;
    end
  end

  assign trn.trn_td         = td_q;
  assign trn.trn_trem_n     = trem_n_q;
  assign trn.trn_tsof_n     = tsof_n_q;
  assign trn.trn_teof_n     = teof_n_q;
  assign trn.trn_tsrc_rdy_n = tsrc_rdy_n_q;
  assign trn.tx_req         = tx_req_q;
  assign trn.tx_done        = tx_done_q;
  assign trn.trn_rnp_ok_n   = rnp_ok_n_q;
  assign trn.reg_rd_addr    = reg_rd_addr_q;
  assign drop_cnt           = drop_cnt_q;
  assign unused_in = ^{trn.trn_rrem_n, trn.trn_reof_n, trn.trn_rbar_hit_n,
                       hdr.first_be, hdr.len, hdr.is_64};

endmodule

// File: tb/tb_mrd_completer.sv
// tb/tb_mrd_completer.sv - directed self-checking bench for mrd_completer
module tb_mrd_completer;
  import mrd_completer_pkg::*;

  logic        trn_clk = 1'b0;
  logic        trn_reset;
  logic [15:0] cfg_completer_id;
  logic [15:0] drop_cnt;
  int          n_checks = 0;
  int          n_fail = 0;
  int          done_cnt = 0;

  typedef struct {
    logic [63:0] td;
    logic [7:0]  rem;
    logic        sof;
    logic        eof;
  } beat_t;
  beat_t beats[$];

  mrd_completer_if bus();

  mrd_completer #(.BAR_HIT_IDX(0)) dut (
    .trn_clk          (trn_clk),
    .trn_reset        (trn_reset),
    .trn              (bus),
    .cfg_completer_id (cfg_completer_id),
    .drop_cnt         (drop_cnt)
  );

  always #5 trn_clk = ~trn_clk;

  function automatic logic [31:0] rf(input logic [9:0] a);
    if (a == 10'h004) return 32'h11223344;
    if (a == 10'h3FF) return 32'hCAFEF00D;
    return {22'h0, a};
  endfunction

  always @(posedge trn_clk) bus.reg_rd_data <= rf(bus.reg_rd_addr);

  always @(negedge trn_clk) begin
    beat_t b;
    if (!trn_reset) begin
      if (!bus.trn_tsrc_rdy_n && !bus.trn_tdst_rdy_n) begin
        b.td  = bus.trn_td;
        b.rem = bus.trn_trem_n;
        b.sof = bus.trn_tsof_n;
        b.eof = bus.trn_teof_n;
        beats.push_back(b);
      end
      if (bus.tx_done) done_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge trn_clk);
    #1;
  endtask

  task automatic send_mrd(input logic [1:0] fmt, input logic [9:0] len, input logic [3:0] be,
                          input logic [7:0] tag, input logic [15:0] rid, input logic [2:0] tc,
                          input logic [1:0] attr, input logic [63:0] qw1);
    bus.trn_rd         = {1'b0, fmt, 5'b0, 1'b0, tc, 4'b0, 2'b00, attr, 2'b00, len,
                          rid, tag, 4'b0, be};
    bus.trn_rsof_n     = 1'b0;
    bus.trn_reof_n     = 1'b1;
    bus.trn_rsrc_rdy_n = 1'b0;
    bus.trn_rbar_hit_n = 7'h7E;
    tick();
    bus.trn_rd         = qw1;
    bus.trn_rsof_n     = 1'b1;
    bus.trn_reof_n     = 1'b0;
    tick();
    bus.trn_rd         = '0;
    bus.trn_reof_n     = 1'b1;
    bus.trn_rsrc_rdy_n = 1'b1;
    bus.trn_rbar_hit_n = 7'h7F;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 80; i++) begin
      if (done_cnt > 0) break;
      tick();
    end
    check_eq({tag, "_done_seen"}, 64'(done_cnt > 0), 64'd1);
    tick();
    tick();
  endtask

  task automatic check_cpl(input string tag, input logic [63:0] qw0, input logic [63:0] qw1,
                           input logic [7:0] rem1);
    check_eq({tag, "_n_beats"}, 64'(beats.size()), 64'd2);
    check_eq({tag, "_n_done"}, 64'(done_cnt), 64'd1);
    if (beats.size() == 2) begin
      check_eq({tag, "_qw0"}, beats[0].td, qw0);
      check_eq({tag, "_qw0_flags"}, {beats[0].rem, beats[0].sof, beats[0].eof}, {8'h00, 1'b0, 1'b1});
      check_eq({tag, "_qw1"}, beats[1].td, qw1);
      check_eq({tag, "_qw1_flags"}, {beats[1].rem, beats[1].sof, beats[1].eof}, {rem1, 1'b1, 1'b0});
    end
  endtask

  task automatic clear_mon;
    beats.delete();
    done_cnt = 0;
  endtask

  initial begin
    trn_reset          = 1'b1;
    cfg_completer_id   = 16'h0100;
    bus.trn_rd         = '0;
    bus.trn_rrem_n     = 8'h00;
    bus.trn_rsof_n     = 1'b1;
    bus.trn_reof_n     = 1'b1;
    bus.trn_rsrc_rdy_n = 1'b1;
    bus.trn_rsrc_dsc_n = 1'b1;
    bus.trn_rbar_hit_n = 7'h7F;
    bus.trn_tdst_rdy_n = 1'b0;
    bus.tx_gnt         = 1'b1;
    tick();
    tick();
    check_eq("rst_tx_ctl", {bus.trn_tsrc_rdy_n, bus.trn_tsof_n, bus.trn_teof_n, bus.trn_trem_n},
             {1'b1, 1'b1, 1'b1, 8'hFF});
    check_eq("rst_td", bus.trn_td, 64'h0);
    check_eq("rst_misc", {bus.tx_req, bus.tx_done, bus.trn_rnp_ok_n, bus.reg_rd_addr, drop_cnt},
             {1'b0, 1'b0, 1'b0, 10'h0, 16'h0});
    trn_reset = 1'b0;
    tick();

    // MRd32 to 0x10: single-DW read, payload byte-swapped
    clear_mon();
    send_mrd(FMT_3DW_NODATA, 10'd1, 4'hF, 8'h05, 16'hABCD, 3'd0, 2'b00, {32'h0000_0010, 32'h0});
    wait_done("mrd32");
    check_cpl("mrd32", 64'h4A000001_01000004, 64'hABCD0510_44332211, 8'h00);
    check_eq("mrd32_reg_addr", 64'(bus.reg_rd_addr), 64'h004);

    // MRd64 to 0x1_0000_0FFC: top register, TC/attr echoed
    clear_mon();
    send_mrd(FMT_4DW_NODATA, 10'd1, 4'hF, 8'h7E, 16'h1234, 3'd2, 2'b10, {32'h1, 32'h0000_0FFC});
    wait_done("mrd64");
    check_cpl("mrd64", 64'h4A202001_01000004, 64'h12347E7C_0DF0FECA, 8'h00);
    check_eq("mrd64_reg_addr", 64'(bus.reg_rd_addr), 64'h3FF);

    // Destination stalls QW0 for five cycles
    clear_mon();
    bus.trn_tdst_rdy_n = 1'b1;
    send_mrd(FMT_3DW_NODATA, 10'd1, 4'hF, 8'h09, 16'h0001, 3'd0, 2'b00, {32'h0000_0020, 32'h0});
    for (int i = 0; i < 40; i++) begin
      if (!bus.trn_tsrc_rdy_n) break;
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_qw0_hold", {bus.trn_td, bus.trn_tsrc_rdy_n, bus.trn_tsof_n},
               {64'h4A000001_01000004, 1'b0, 1'b0});
      tick();
    end
    bus.trn_tdst_rdy_n = 1'b0;
    wait_done("stall");
    check_cpl("stall", 64'h4A000001_01000004, 64'h00010920_08000000, 8'h00);

    // Second MRd while waiting for the Tx grant is dropped and counted
    clear_mon();
    bus.tx_gnt = 1'b0;
    send_mrd(FMT_3DW_NODATA, 10'd1, 4'hF, 8'h11, 16'h2222, 3'd0, 2'b00, {32'h0000_0030, 32'h0});
    for (int i = 0; i < 20; i++) begin
      if (bus.tx_req) break;
      tick();
    end
    check_eq("busy_tx_req", 64'(bus.tx_req), 64'd1);
    send_mrd(FMT_3DW_NODATA, 10'd1, 4'hF, 8'h12, 16'h2222, 3'd0, 2'b00, {32'h0000_0040, 32'h0});
    check_eq("busy_drop_cnt", 64'(drop_cnt), 64'd1);
    check_eq("busy_rnp_ok_n", 64'(bus.trn_rnp_ok_n), 64'd1);
    bus.tx_gnt = 1'b1;
    wait_done("busy");
    check_cpl("busy", 64'h4A000001_01000004, 64'h22221130_0C000000, 8'h00);
    check_eq("busy_rnp_idle", 64'(bus.trn_rnp_ok_n), 64'd0);

    // Length 2: unsupported
    clear_mon();
    send_mrd(FMT_3DW_NODATA, 10'd2, 4'hF, 8'h22, 16'h3333, 3'd0, 2'b00, {32'h0000_0040, 32'h0});
`ifdef MRD_UR_CPL_EN
    wait_done("ur");
    check_cpl("ur", 64'h0A000000_01002004, 64'h33332240_00000000, 8'h0F);
    check_eq("ur_drop_cnt", 64'(drop_cnt), 64'd1);
`else
    repeat (15) tick();
    check_eq("unsup_n_beats", 64'(beats.size()), 64'd0);
    check_eq("unsup_drop_cnt", 64'(drop_cnt), 64'd2);
    check_eq("unsup_rnp_ok_n", 64'(bus.trn_rnp_ok_n), 64'd0);
`endif

    // Reset while QW1 is held on the link
    clear_mon();
    bus.trn_tdst_rdy_n = 1'b1;
    send_mrd(FMT_3DW_NODATA, 10'd1, 4'hF, 8'h33, 16'h4444, 3'd0, 2'b00, {32'h0000_0010, 32'h0});
    for (int i = 0; i < 40; i++) begin
      if (!bus.trn_tsrc_rdy_n && !bus.trn_tsof_n) break;
      tick();
    end
    bus.trn_tdst_rdy_n = 1'b0;
    tick();
    bus.trn_tdst_rdy_n = 1'b1;
    tick();
    check_eq("rst_mid_qw1_eof", {bus.trn_tsrc_rdy_n, bus.trn_teof_n}, {1'b0, 1'b0});
    #2;
    trn_reset = 1'b1;
    #1;
    check_eq("rst_async_tx", {bus.trn_tsrc_rdy_n, bus.tx_req, bus.trn_trem_n}, {1'b1, 1'b0, 8'hFF});
    check_eq("rst_async_cnt", 64'(drop_cnt), 64'd0);
    tick();
    tick();
    trn_reset = 1'b0;
    clear_mon();
    bus.trn_tdst_rdy_n = 1'b0;
    repeat (20) tick();
    check_eq("rst_no_beats", 64'(beats.size()), 64'd0);
    check_eq("rst_no_done", 64'(done_cnt), 64'd0);
    check_eq("rst_idle_ctl", {bus.tx_req, bus.trn_tsrc_rdy_n, bus.trn_rnp_ok_n}, {1'b0, 1'b1, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mrd_completer.md
MRD_COMPLETER -- requirements
Module: mrd_completer

Interface
REQ-001 SHALL have parameter BAR_HIT_IDX, default 0, meaning the trn_rbar_hit_n bit index served.
REQ-002 SHALL have port trn_clk  in  1  clock for all logic.
REQ-003 SHALL have port trn_reset  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports trn_rd in 64, trn_rrem_n in 8, trn_rsof_n in 1, trn_reof_n in 1, trn_rsrc_rdy_n in 1, trn_rsrc_dsc_n in 1, trn_rbar_hit_n in 7, all meaning the Rx local-link.
REQ-005 SHALL have ports trn_td out 64, trn_trem_n out 8, trn_tsof_n out 1, trn_teof_n out 1, trn_tsrc_rdy_n out 1, trn_tdst_rdy_n in 1, all meaning the Tx local-link.
REQ-006 SHALL have port cfg_completer_id  in  16  {bus,dev,fn}.
REQ-007 SHALL have port trn_rnp_ok_n  out  1  non-posted throttle, driven 1 while busy.
REQ-008 SHALL have ports tx_req out 1, tx_gnt in 1, tx_done out 1, meaning the Tx arbitration handshake shared with the packet-write engine.
REQ-009 SHALL have ports reg_rd_addr out 10 (DW address) and reg_rd_data in 32 (valid one cycle after reg_rd_addr), meaning the register file read port.
REQ-010 SHALL have port drop_cnt  out  16  count of discarded MRd TLPs.

Function
REQ-011 SHALL accept a TLP only at beat with rsof_n=0, rsrc_rdy_n=0, and trn_rbar_hit_n[BAR_HIT_IDX]=0.
REQ-012 SHALL decode DW0 fmt/type 2'b00/5'b00000 as MRd32 and 2'b01/5'b00000 as MRd64; all other TLPs SHALL be ignored.
REQ-013 SHALL capture the requester ID (DW1[31:16]), tag (DW1[15:8]), first BE (DW1[3:0]), TC (DW0[22:20]), attr (DW0[13:12]), and length (DW0[9:0]).
REQ-014 SHALL take the address from QW1[63:32] for MRd32 and QW1[31:0] for MRd64, and SHALL set reg_rd_addr = addr[11:2].
REQ-015 SHALL classify as supported only length=1 with first BE=4'hF; all others are unsupported.
REQ-016 SHALL use FSM states IDLE -> HDR2 (second beat) -> RDREG (one cycle) -> REQ (tx_req=1 until tx_gnt=1) -> QW0 -> QW1 -> IDLE.
REQ-017 SHALL abort to IDLE without response if trn_rsrc_dsc_n=0 during HDR2.
REQ-018 SHALL drive CplD QW0 as {fmt 2'b10, type 5'b01010, TC, attr, length 1 ; completer_id, status 3'b000, BCM 0, byte count 12'd4}.
REQ-019 SHALL drive CplD QW1 as {requester ID, tag, 1'b0, lower_addr = {addr[6:2], 2'b00} ; byte-swapped reg_rd_data}, with trn_trem_n=8'h00.
REQ-020 SHALL hold each Tx beat stable until sampled with trn_tdst_rdy_n=0; tsof_n=0 only on QW0, teof_n=0 only on QW1.
REQ-021 SHALL pulse tx_done for one cycle when the QW1 beat is accepted, and SHALL drop tx_req in the cycle after tx_gnt is seen.
REQ-022 SHALL hold trn_rnp_ok_n=1 in every state except IDLE.
REQ-023 SHALL silently ignore an MRd whose SOF arrives while not IDLE and SHALL increment drop_cnt, saturating at 16'hFFFF.
REQ-024 SHALL latch reg_rd_data in RDREG and hold it through QW1.

Reset
REQ-025 SHALL force on trn_reset, at any time: state IDLE, trn_tsrc_rdy_n=1, trn_tsof_n=1, trn_teof_n=1, trn_td=0, trn_trem_n=8'hFF, tx_req=0, tx_done=0, trn_rnp_ok_n=0, reg_rd_addr=0, drop_cnt=0.
REQ-026 SHALL abandon any in-progress TLP on reset, and SHALL NOT emit a partial TLP afterwards.

Configuration
REQ-027 SHALL, with MRD_UR_CPL_EN defined, answer unsupported MRd with a Cpl of fmt 2'b00, type 5'b01010, length 0, status 3'b001, byte count 4, sent as QW0 plus QW1 containing only DW2 (trn_trem_n=8'h0F).
REQ-028 SHALL, without MRD_UR_CPL_EN, drop unsupported MRd and increment drop_cnt.

Structure
REQ-029 SHALL place the fmt/type constants, completion status codes, and FSM state encoding in the shared package/includes.v.
REQ-030 SHALL use one sub-module, mrd_hdr_parse, for the Rx header capture and classification.

Verification
REQ-031 SHALL verify: MRd32 addr 0x0000_0010, tag 0x05, reg_rd_data 0x11223344 -> CplD with byte count 4, lower_addr 0x10, data DW 0x44332211.
REQ-032 SHALL verify: MRd64 addr hi 0x1, lo 0x0000_0FFC -> reg_rd_addr=10'h3FF and a correct CplD.
REQ-033 SHALL verify: trn_tdst_rdy_n=1 for 5 cycles during QW0 -> beat held, then exactly one TLP and one tx_done.
REQ-034 SHALL verify: second MRd during REQ -> ignored, drop_cnt=1, trn_rnp_ok_n=1 until return to IDLE.
REQ-035 SHALL verify: length=2 MRd -> UR Cpl status 001 with MRD_UR_CPL_EN defined; no Tx and drop_cnt+1 without it.
REQ-036 SHALL verify: trn_reset asserted mid-QW1 -> trn_tsrc_rdy_n=1 immediately, tx_req=0, and no further beats after reset release.
